// File: rtl/frac_lut_k.sv
// Fracturable K-input LUT with a serial configuration chain, a load-integrity
// state machine and per-output registered/bypass selection.
module frac_lut_k #(
    parameter int K = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [0:K-1] in,
    input  logic         cfg_en,
    input  logic         ccff_head,
    output logic         ccff_tail,
    output logic [0:1]   lut_k1_out,
    output logic [0:0]   lut_k_out,
    output logic         cfg_valid,
    output logic         cfg_err
);

    localparam int SRAM_N  = 2 ** K;
    localparam int CFG_LEN = SRAM_N + 3;
    localparam int CNT_W   = $clog2(CFG_LEN + 2);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CFG_LEN);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(CFG_LEN + 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_ACTIVE = 2'd2
    } state_t;

    state_t              state_r;
    state_t              state_next_s;
    logic [CNT_W-1:0]    cnt_r;
    logic [CNT_W-1:0]    cnt_next_s;
    logic                err_next_s;
    logic                cfg_err_r;
    logic                cfg_valid_r;
    logic [CFG_LEN-1:0]  cfg_r;
    logic [SRAM_N-1:0]   sram_s;
    logic                mode_s;
    logic                reg_k1_s;
    logic                reg_k_s;
    logic [K-2:0]        addr_lo_s;
    logic                top_s;
    logic                raw_k_s;
    logic [1:0]          raw_k1_s;
    logic                ff_k_r;
    logic [1:0]          ff_k1_r;

    assign sram_s    = cfg_r[SRAM_N-1:0];
    assign mode_s    = cfg_r[SRAM_N];
    assign reg_k1_s  = cfg_r[SRAM_N+1];
    assign reg_k_s   = cfg_r[SRAM_N+2];
    assign ccff_tail = cfg_r[CFG_LEN-1];
    assign cfg_valid = cfg_valid_r;
    assign cfg_err   = cfg_err_r;

    // Configuration shift chain; reset wins over a concurrent shift request.
    always_ff @(posedge clk) begin
        if (reset) begin
            cfg_r <= '0;
        end else if (cfg_en) begin
            cfg_r <= {cfg_r[CFG_LEN-2:0], ccff_head};
        end
    end

    // LUT address decode; mode forces the top input high so lut_k tracks the upper half.
    always_comb begin
        addr_lo_s = '0;
        for (int i = 0; i < K - 1; i++) begin
            addr_lo_s[i] = in[i];
        end
        top_s       = in[K-1] | mode_s;
        raw_k_s     = sram_s[{top_s, addr_lo_s}];
        raw_k1_s[0] = sram_s[{1'b0, addr_lo_s}];
        raw_k1_s[1] = sram_s[{1'b1, addr_lo_s}];
    end

    // Load-integrity next-state logic and bit counter.
    always_comb begin
        state_next_s = state_r;
        cnt_next_s   = cnt_r;
        err_next_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (cfg_en) begin
                    state_next_s = ST_LOAD;
                    cnt_next_s   = CNT_W'(1);
                end else begin
                    cnt_next_s   = '0;
                end
            end
            ST_LOAD: begin
                if (cfg_en) begin
                    if (cnt_r != CNT_MAX) begin
                        cnt_next_s = cnt_r + CNT_W'(1);
                    end else begin
                        cnt_next_s = cnt_r;
                    end
                end else if (cnt_r == CNT_FULL) begin
                    state_next_s = ST_ACTIVE;
                    cnt_next_s   = '0;
                end else begin
                    state_next_s = ST_IDLE;
                    cnt_next_s   = '0;
                    err_next_s   = 1'b1;
                end
            end
            ST_ACTIVE: begin
                if (cfg_en) begin
                    state_next_s = ST_LOAD;
                    cnt_next_s   = CNT_W'(1);
                end else begin
                    cnt_next_s   = cnt_r;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
                cnt_next_s   = '0;
            end
        endcase
    end

    // State, counter and status registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            cnt_r       <= '0;
            cfg_err_r   <= 1'b0;
            cfg_valid_r <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            cnt_r       <= cnt_next_s;
            cfg_err_r   <= err_next_s;
            cfg_valid_r <= (state_next_s == ST_ACTIVE);
        end
    end

    // Output flip-flops capture only while staying ACTIVE; leaving ACTIVE clears them.
    always_ff @(posedge clk) begin
        if (reset) begin
            ff_k_r  <= 1'b0;
            ff_k1_r <= 2'b00;
        end else if ((state_r == ST_ACTIVE) && !cfg_en) begin
            ff_k_r  <= raw_k_s;
            ff_k1_r <= raw_k1_s;
        end else begin
            ff_k_r  <= 1'b0;
            ff_k1_r <= 2'b00;
        end
    end

    // Registered/bypass output selection, gated to zero outside ACTIVE.
    always_comb begin
        lut_k1_out = 2'b00;
        lut_k_out  = 1'b0;
        if (state_r == ST_ACTIVE) begin
            lut_k1_out[0] = reg_k1_s ? ff_k1_r[0] : raw_k1_s[0];
            lut_k1_out[1] = reg_k1_s ? ff_k1_r[1] : raw_k1_s[1];
            lut_k_out[0]  = reg_k_s  ? ff_k_r     : raw_k_s;
        end else begin
            lut_k1_out = 2'b00;
            lut_k_out  = 1'b0;
        end
    end

endmodule

// File: tb/tb_frac_lut_k.sv
// Directed, table-driven bench for frac_lut_k with K=4 (19-bit configuration chain).
module tb_frac_lut_k;

    localparam int K = 4;
    localparam int CFG_LEN = 19;

    logic         clk;
    logic         reset;
    logic [0:K-1] lut_in;
    logic         cfg_en;
    logic         ccff_head;
    logic         ccff_tail;
    logic [0:1]   lut_k1_out;
    logic [0:0]   lut_k_out;
    logic         cfg_valid;
    logic         cfg_err;

    int total;
    int bad;

    // image layout: {reg_k, reg_k1, mode, sram[15:0]}
    localparam logic [18:0] IMG_XOR4   = {1'b0, 1'b0, 1'b0, 16'h6996};
    localparam logic [18:0] IMG_FRAC   = {1'b0, 1'b0, 1'b1, 16'h96E8};
    localparam logic [18:0] IMG_XOR4_R = {1'b1, 1'b0, 1'b0, 16'h6996};
    localparam logic [18:0] IMG_FRAC_R = {1'b0, 1'b1, 1'b1, 16'h96E8};
    localparam logic [18:0] IMG_ONES   = 19'h7FFFF;

    typedef struct {
        logic [3:0] in_v;
        logic       exp_maj;
        logic       exp_x3;
    } frac_vec_t;

    frac_vec_t fv [8];

    frac_lut_k #(.K(K)) dut (
        .clk        (clk),
        .reset      (reset),
        .in         (lut_in),
        .cfg_en     (cfg_en),
        .ccff_head  (ccff_head),
        .ccff_tail  (ccff_tail),
        .lut_k1_out (lut_k1_out),
        .lut_k_out  (lut_k_out),
        .cfg_valid  (cfg_valid),
        .cfg_err    (cfg_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic [3:0] v);
        for (int i = 0; i < K; i++) lut_in[i] = v[i];
    endtask

    task automatic shift_bits(input logic [18:0] img, input int n);
        for (int i = 0; i < n; i++) begin
            cfg_en    = 1'b1;
            ccff_head = (i < CFG_LEN) ? img[18-i] : 1'b0;
            step();
        end
        cfg_en    = 1'b0;
        ccff_head = 1'b0;
    endtask

    task automatic load_image(input logic [18:0] img);
        shift_bits(img, CFG_LEN);
        #1;
        check("valid_before_drop", cfg_valid, 1'b0);
        step();
        check("valid_rise", cfg_valid, 1'b1);
        check("no_err_on_good_load", cfg_err, 1'b0);
    endtask

    task automatic bad_load(input int n, input string tag);
        set_in(4'hF);
        shift_bits(IMG_ONES, n);
        step();
        check({tag, "_err_pulse"}, cfg_err, 1'b1);
        check({tag, "_valid"}, cfg_valid, 1'b0);
        check({tag, "_k1_zero"}, lut_k1_out, 2'b00);
        check({tag, "_k_zero"}, lut_k_out, 1'b0);
        step();
        check({tag, "_err_one_cycle"}, cfg_err, 1'b0);
        check({tag, "_still_idle"}, cfg_valid, 1'b0);
        check({tag, "_k_zero_after"}, lut_k_out, 1'b0);
    endtask

    initial begin
        logic [3:0] v;
        total = 0;
        bad   = 0;

        fv[0] = '{4'b0000, 1'b0, 1'b0};
        fv[1] = '{4'b0011, 1'b1, 1'b0};
        fv[2] = '{4'b1011, 1'b1, 1'b0};
        fv[3] = '{4'b0111, 1'b1, 1'b1};
        fv[4] = '{4'b0001, 1'b0, 1'b1};
        fv[5] = '{4'b1110, 1'b1, 1'b0};
        fv[6] = '{4'b1100, 1'b0, 1'b1};
        fv[7] = '{4'b0101, 1'b1, 1'b0};

        // reset with a concurrent shift request
        reset = 1'b1; cfg_en = 1'b1; ccff_head = 1'b1; set_in(4'hF);
        repeat (3) step();
        check("rst_k1", lut_k1_out, 2'b00);
        check("rst_k", lut_k_out, 1'b0);
        check("rst_valid", cfg_valid, 1'b0);
        check("rst_err", cfg_err, 1'b0);
        check("rst_tail", ccff_tail, 1'b0);
        reset = 1'b0; cfg_en = 1'b0; ccff_head = 1'b0;
        step();
        check("idle_valid", cfg_valid, 1'b0);
        check("idle_k", lut_k_out, 1'b0);

        // full 4-input XOR, exhaustive
        load_image(IMG_XOR4);
        for (int i = 0; i < 16; i++) begin
            v = 4'(i);
            set_in(v);
            #1;
            check("xor4_k", lut_k_out, ^v);
            check("xor4_k1_0", lut_k1_out[0], ^v[2:0]);
        end

        // fractured majority / XOR3
        load_image(IMG_FRAC);
        for (int i = 0; i < 8; i++) begin
            set_in(fv[i].in_v);
            #1;
            check("frac_maj", lut_k1_out[0], fv[i].exp_maj);
            check("frac_x3", lut_k1_out[1], fv[i].exp_x3);
            check("frac_k", lut_k_out, fv[i].exp_x3);
        end

        // aborted loads: short and overshifted
        bad_load(18, "short");
        bad_load(20, "long");

        // registered lut_k, bypassed lut_k1
        set_in(4'h0);
        load_image(IMG_XOR4_R);
        check("reg_entry_zero", lut_k_out, 1'b0);
        step();
        check("reg_in0", lut_k_out, 1'b0);
        set_in(4'h1);
        #1;
        check("reg_hold_before_edge", lut_k_out, 1'b0);
        check("bypass_k1_immediate", lut_k1_out, 2'b10);
        step();
        check("reg_in1", lut_k_out, 1'b1);
        set_in(4'h3);
        #1;
        check("reg_hold_1", lut_k_out, 1'b1);
        check("bypass_k1_in3", lut_k1_out, 2'b01);
        step();
        check("reg_in3", lut_k_out, 1'b0);
        set_in(4'h1);
        step();
        check("reg_ff_loaded", lut_k_out, 1'b1);

        // reconfiguration: old image streams out of ccff_tail
        for (int i = 0; i < CFG_LEN; i++) begin
            check("tail_old_bit", ccff_tail, IMG_XOR4_R[18-i]);
            cfg_en    = 1'b1;
            ccff_head = IMG_FRAC_R[18-i];
            step();
            if (i == 0) begin
                check("reconf_valid_drop", cfg_valid, 1'b0);
                check("reconf_k_zero", lut_k_out, 1'b0);
            end
        end
        cfg_en = 1'b0; ccff_head = 1'b0;
        set_in(4'h7);
        #1;
        check("reconf_not_yet_valid", cfg_valid, 1'b0);
        check("tail_new_first_bit", ccff_tail, IMG_FRAC_R[18]);
        step();
        check("reconf_valid", cfg_valid, 1'b1);
        check("reconf_k1_ff_cleared", lut_k1_out, 2'b00);
        check("reconf_k_bypass", lut_k_out, 1'b1);
        step();
        check("reconf_k1_registered", lut_k1_out, 2'b11);
        set_in(4'h4);
        #1;
        check("reconf_k1_held", lut_k1_out, 2'b11);
        check("reconf_k_follow", lut_k_out, 1'b1);
        step();
        check("reconf_k1_next", lut_k1_out, 2'b01);

        // reset mid-load discards the partial count
        shift_bits(IMG_ONES, 10);
        reset = 1'b1;
        cfg_en = 1'b1;
        step();
        reset = 1'b0;
        cfg_en = 1'b0;
        #1;
        check("midload_rst_tail", ccff_tail, 1'b0);
        check("midload_rst_valid", cfg_valid, 1'b0);
        check("midload_rst_err", cfg_err, 1'b0);
        step();
        check("midload_no_err", cfg_err, 1'b0);
        load_image(IMG_XOR4);
        set_in(4'hB);
        #1;
        check("after_rst_xor4", lut_k_out, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
